periph_bus_slave: RTL and testbench
===================================

// Module: periph_bus_slave
// PURPOSE
//  Memory-mapped peripheral responder for the MIPS core's data bus at BASE_ADDR.
//  Holds the timer, LED, 7-seg, switch and UART-byte registers that the boot
//  firmware reads and writes. Raises the timer IRQ and handshakes bytes with the
//  UART RX/TX serial engines. Read data is combinational for the single-cycle
//  datapath; all register updates happen on clk.
// PARAMETERS
//  BASE_ADDR  32'h4000_0000  region base; must be 256-byte aligned
//  LED_W      8              LED register / port width
//  SW_W       8              switch input width
// PORTS
//  clk       in   1   system clock
//  reset     in   1   synchronous reset, active-high
//  rd        in   1   bus read strobe
//  wr        in   1   bus write strobe, sampled on clk rising edge
//  addr      in   32  byte address; hit when addr[31:8]==BASE_ADDR[31:8]
//  wdata     in   32  write data
//  rdata     out  32  read data, combinational
//  irq       out  1   timer interrupt request, level
//  led       out  LED_W  LED register
//  switch    in   SW_W   board switches
//  digi      out  12  7-seg drive {an[3:0],seg[7:0]}
//  rx_data   in   8   byte from UART receiver
//  rx_valid  in   1   one-cycle strobe: rx_data valid
//  tx_data   out  8   TXD[7:0] to UART transmitter
//  tx_start  out  1   one-cycle strobe: start transmission
//  tx_busy   in   1   transmitter busy
// BEHAVIOUR
//  Map (offset addr[7:2]*4; addr[1:0] ignored; unmapped/miss reads 0, writes dropped):
//   0x00 TH   RW32 | 0x04 TL RW32 | 0x08 TCON RW[2:0] {irq_st,irq_en,tmr_en}
//   0x0C LED  RW   | 0x10 SW RO   | 0x14 DIGI RW[11:0]
//   0x18 RXD0 RO[7:0] | 0x1C RXD1 RO[7:0] | 0x20 TXD RW[7:0]
//   0x24 UCON {bit3 rx_ovr, bit2 tx_busy RO, bit1 tx_go WO(reads 0), bit0 rx_pair}
//  rdata = 0 when rd==0. Reset: all registers, irq, tx_start, led, digi = 0; RX FSM = WAIT_A.
//  Timer: tmr_en=1 -> TL increments each clk; at TL==32'hFFFF_FFFF, TL<=TH and
//   irq_st<=1 if irq_en. irq = irq_en & irq_st. CPU write to TL/TCON same
//   cycle as increment/reload: write wins (overflow event for that cycle lost).
//  RX FSM, states WAIT_A/WAIT_B; bytes accepted only while rx_pair==0:
//   WAIT_A + rx_valid -> RXD0<=rx_data, go WAIT_B.
//   WAIT_B + rx_valid -> RXD1<=rx_data, rx_pair<=1, go WAIT_A.
//   rx_valid while rx_pair==1 -> byte dropped, rx_ovr<=1, state unchanged.
//  UCON write: bit0/bit3 are write-0-to-clear (writing 1 leaves them);
//   rx_valid setting a bit in the same cycle as its clear: set wins.
//   bit1=1 and tx_busy==0 -> tx_start=1 next cycle, one cycle only;
//   bit1=1 while tx_busy==1 -> ignored, no pulse. tx_data always = TXD[7:0].
//  Reset mid-operation discards a half-received pair and a pending tx_start.
// CONFIGURATION
//  PERIPH_SYSTICK_EN defined: 0x28 SYSTICK RO32 free-running cycle counter,
//   +1 per clk, wraps FFFF_FFFF->0; any write to 0x28 clears it to 0.
//  Undefined: 0x28 unmapped (reads 0, writes dropped), no counter logic.
// TESTING
//  1 TH=FFFF_FFFE,TL=FFFF_FFFD,TCON=3 -> TL==FFFF_FFFF after 2 clk; reload to FFFF_FFFE and irq=1 next clk; write TCON=3 -> irq=0.
//  2 rx_valid bytes 0x0C then 0x12 -> RXD0=0x0C,RXD1=0x12,UCON=0x1; third byte 0x55 -> dropped, UCON=0x9; write UCON=0 -> 0x0.
//  3 TXD=0x06, UCON=2 with tx_busy=0 -> tx_start 1 cycle, tx_data=0x06; repeat with tx_busy=1 -> no pulse, UCON reads 0x4.
//  4 rx_valid in the cycle UCON=0 written while rx_pair=1 -> byte dropped, rx_ovr=1, rx_pair stays 1; TL write during tmr_en=1 -> TL=written value.
//  5 reset asserted in WAIT_B after byte 0x0C -> next bytes 0x21,0x33 land RXD0=0x21,RXD1=0x33.
//  6 SYSTICK_EN: read 0x28 twice N clk apart -> difference N; write 0x28 -> reads 0 next clk; without macro -> 0x28 reads 0.

Source files
------------

// File: rtl/periph_bus_slave.sv
// Memory-mapped peripheral responder: timer, LED, 7-seg, switches, UART byte pair/TX.
// Optional free-running cycle counter at offset 0x28 when PERIPH_SYSTICK_EN is defined.
module periph_bus_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          SW_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd,
    input  logic             wr,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  switch,
    output logic [11:0]      digi,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_start,
    input  logic             tx_busy
);

    typedef enum logic {
        WAIT_A,
        WAIT_B
    } rx_state_t;

    localparam logic [5:0] OFF_TH      = 6'h00;
    localparam logic [5:0] OFF_TL      = 6'h01;
    localparam logic [5:0] OFF_TCON    = 6'h02;
    localparam logic [5:0] OFF_LED     = 6'h03;
    localparam logic [5:0] OFF_SW      = 6'h04;
    localparam logic [5:0] OFF_DIGI    = 6'h05;
    localparam logic [5:0] OFF_RXD0    = 6'h06;
    localparam logic [5:0] OFF_RXD1    = 6'h07;
    localparam logic [5:0] OFF_TXD     = 6'h08;
    localparam logic [5:0] OFF_UCON    = 6'h09;
    localparam logic [5:0] OFF_SYSTICK = 6'h0A;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [7:0]  rxd0;
    logic [7:0]  rxd1;
    logic [7:0]  txd;
    logic        rx_pair;
    logic        rx_ovr;
    rx_state_t   rx_state;
    rx_state_t   rx_state_nxt;
    logic        load_rxd0;
    logic        load_rxd1;
    logic        pair_set;
    logic        ovr_set;

    logic        hit;
    logic [5:0]  off;
    logic        we;
    logic        th_we;
    logic        tl_we;
    logic        tcon_we;
    logic        ucon_we;
    logic        unused_bits;

    assign hit         = (addr[31:8] == BASE_ADDR[31:8]);
    assign off         = addr[7:2];
    assign we          = wr && hit;
    assign th_we       = we && (off == OFF_TH);
    assign tl_we       = we && (off == OFF_TL);
    assign tcon_we     = we && (off == OFF_TCON);
    assign ucon_we     = we && (off == OFF_UCON);
    assign unused_bits = ^addr[1:0];

    assign irq     = tcon[1] & tcon[2];
    assign tx_data = txd;

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick;

    always_ff @(posedge clk) begin
        if (reset) begin
            systick <= '0;
        end else if (we && (off == OFF_SYSTICK)) begin
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (rd && hit) begin
            case (off)
                OFF_TH:      rdata = th;
                OFF_TL:      rdata = tl;
                OFF_TCON:    rdata = {29'd0, tcon};
                OFF_LED:     rdata = 32'(led);
                OFF_SW:      rdata = 32'(switch);
                OFF_DIGI:    rdata = {20'd0, digi};
                OFF_RXD0:    rdata = {24'd0, rxd0};
                OFF_RXD1:    rdata = {24'd0, rxd1};
                OFF_TXD:     rdata = {24'd0, txd};
                OFF_UCON:    rdata = {28'd0, rx_ovr, tx_busy, 1'b0, rx_pair};
`ifdef PERIPH_SYSTICK_EN
                OFF_SYSTICK: rdata = systick;
`endif
                default:     rdata = '0;
            endcase
        end
    end

    // A byte arriving while a pair is pending is dropped but re-asserts rx_pair,
    // so a simultaneous software clear cannot hide the unread pair.
    always_comb begin
        rx_state_nxt = rx_state;
        load_rxd0    = 1'b0;
        load_rxd1    = 1'b0;
        pair_set     = 1'b0;
        ovr_set      = 1'b0;
        if (rx_valid) begin
            if (rx_pair) begin
                ovr_set  = 1'b1;
                pair_set = 1'b1;
            end else begin
                case (rx_state)
                    WAIT_A: begin
                        load_rxd0    = 1'b1;
                        rx_state_nxt = WAIT_B;
                    end
                    WAIT_B: begin
                        load_rxd1    = 1'b1;
                        pair_set     = 1'b1;
                        rx_state_nxt = WAIT_A;
                    end
                    default: rx_state_nxt = WAIT_A;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= WAIT_A;
        end else begin
            rx_state <= rx_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th       <= '0;
            tl       <= '0;
            tcon     <= '0;
            led      <= '0;
            digi     <= '0;
            rxd0     <= '0;
            rxd1     <= '0;
            txd      <= '0;
            rx_pair  <= 1'b0;
            rx_ovr   <= 1'b0;
            tx_start <= 1'b0;
        end else begin
            // Timer; a same-cycle CPU write to TL or TCON swallows the overflow event.
            if (tcon[0]) begin
                if (tl == 32'hFFFF_FFFF) begin
                    tl <= th;
                    if (tcon[1] && !tl_we && !tcon_we) begin
                        tcon[2] <= 1'b1;
                    end
                end else begin
                    tl <= tl + 32'd1;
                end
            end
            if (th_we)   th   <= wdata;
            if (tl_we)   tl   <= wdata;
            if (tcon_we) tcon <= wdata[2:0];
            if (we && (off == OFF_LED))  led  <= wdata[LED_W-1:0];
            if (we && (off == OFF_DIGI)) digi <= wdata[11:0];
            if (we && (off == OFF_TXD))  txd  <= wdata[7:0];

            if (load_rxd0) rxd0 <= rx_data;
            if (load_rxd1) rxd1 <= rx_data;

            if (ucon_we && !wdata[0]) rx_pair <= 1'b0;
            if (pair_set)             rx_pair <= 1'b1;
            if (ucon_we && !wdata[3]) rx_ovr  <= 1'b0;
            if (ovr_set)              rx_ovr  <= 1'b1;

            tx_start <= ucon_we && wdata[1] && !tx_busy;
        end
    end

endmodule

// File: tb/tb_periph_bus_slave.sv
// Table-driven directed bench for periph_bus_slave; each row is one bus cycle.
// Set PERIPH_SYSTICK_EN on the command line to exercise the cycle counter.
module tb_periph_bus_slave;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] TH = 32'h00, TL = 32'h04, TCON = 32'h08, LED = 32'h0C;
    localparam logic [31:0] SW = 32'h10, DIGI = 32'h14, RXD0 = 32'h18, RXD1 = 32'h1C;
    localparam logic [31:0] TXD = 32'h20, UCON = 32'h24, SYST = 32'h28;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  led;
    logic [7:0]  switch = 8'h3C;
    logic [11:0] digi;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [31:0] off;
        logic [31:0] wdata;
        logic        rxv;
        logic [7:0]  rxd;
        logic        busy;
        logic        chk;
        logic [31:0] exp;
        logic        eirq;
        logic        etxs;
    } vec_t;

    vec_t tbl[$];

    periph_bus_slave #(.BASE_ADDR(BASE), .LED_W(8), .SW_W(8)) dut (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata), .irq(irq), .led(led), .switch(switch), .digi(digi),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic r, logic w, logic [31:0] o, logic [31:0] d,
                                logic [31:0] e, logic ei, logic et,
                                logic rv, logic [7:0] rb, logic b);
        vec_t v;
        v.rst = 1'b0; v.rd = r; v.wr = w; v.off = o; v.wdata = d;
        v.rxv = rv; v.rxd = rb; v.busy = b; v.chk = 1'b1;
        v.exp = e; v.eirq = ei; v.etxs = et;
        return v;
    endfunction

    function automatic vec_t R(logic [31:0] o, logic [31:0] e, logic ei = 0, logic et = 0,
                               logic rv = 0, logic [7:0] rb = 0, logic b = 0);
        return mk(1'b1, 1'b0, o, 32'd0, e, ei, et, rv, rb, b);
    endfunction

    function automatic vec_t W(logic [31:0] o, logic [31:0] d, logic ei = 0, logic et = 0,
                               logic rv = 0, logic [7:0] rb = 0, logic b = 0);
        return mk(1'b0, 1'b1, o, d, 32'd0, ei, et, rv, rb, b);
    endfunction

    function automatic vec_t I(logic ei = 0, logic et = 0,
                               logic rv = 0, logic [7:0] rb = 0, logic b = 0);
        return mk(1'b0, 1'b0, TH, 32'd0, 32'd0, ei, et, rv, rb, b);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic apply(vec_t v, string tag);
        @(negedge clk);
        reset    = v.rst;
        rd       = v.rd;
        wr       = v.wr;
        addr     = BASE + v.off;
        wdata    = v.wdata;
        rx_valid = v.rxv;
        rx_data  = v.rxd;
        tx_busy  = v.busy;
        #1;
        if (v.chk) check({tag, " rdata"}, rdata, v.exp);
        check({tag, " irq"}, {31'd0, irq}, {31'd0, v.eirq});
        check({tag, " tx_start"}, {31'd0, tx_start}, {31'd0, v.etxs});
    endtask

    initial begin
        vec_t v;
        logic [31:0] a;
        logic [31:0] b;

        // timer overflow, reload, irq and write-wins
        tbl.push_back(W(TH, 32'hFFFF_FFFE));
        tbl.push_back(W(TL, 32'hFFFF_FFFD));
        tbl.push_back(W(TCON, 32'h3));
        tbl.push_back(R(TL, 32'hFFFF_FFFD));
        tbl.push_back(R(TL, 32'hFFFF_FFFE));
        tbl.push_back(R(TL, 32'hFFFF_FFFF));
        tbl.push_back(R(TL, 32'hFFFF_FFFE, 1));
        tbl.push_back(W(TCON, 32'h3, 1));
        tbl.push_back(R(TCON, 32'h3));
        tbl.push_back(W(TL, 32'h1234_5678));
        tbl.push_back(R(TL, 32'h1234_5678));
        tbl.push_back(W(TCON, 32'h0));
        tbl.push_back(R(TL, 32'h1234_567A));
        tbl.push_back(R(TL, 32'h1234_567A));
        tbl.push_back(R(TH, 32'hFFFF_FFFE));
        // plain registers, read-only, miss and unmapped
        tbl.push_back(W(LED, 32'hFFFF_FFA5));
        tbl.push_back(R(LED, 32'hA5));
        tbl.push_back(R(LED + 32'd3, 32'hA5));
        tbl.push_back(W(DIGI, 32'hFFFF_FABC));
        tbl.push_back(R(DIGI, 32'hABC));
        tbl.push_back(R(SW, 32'h3C));
        tbl.push_back(W(SW, 32'hFF));
        tbl.push_back(R(SW, 32'h3C));
        tbl.push_back(R(32'h100, 32'h0));
        tbl.push_back(W(32'h100, 32'h1));
        tbl.push_back(R(TH, 32'hFFFF_FFFE));
        tbl.push_back(R(32'h2C, 32'h0));
        tbl.push_back(I());
        // rx pair, overflow, write-0-to-clear
        tbl.push_back(I(0, 0, 1, 8'h0C));
        tbl.push_back(R(UCON, 32'h0, 0, 0, 1, 8'h12));
        tbl.push_back(R(RXD0, 32'h0C));
        tbl.push_back(R(RXD1, 32'h12));
        tbl.push_back(R(UCON, 32'h1, 0, 0, 1, 8'h55));
        tbl.push_back(R(UCON, 32'h9));
        tbl.push_back(R(RXD0, 32'h0C));
        tbl.push_back(R(RXD1, 32'h12));
        tbl.push_back(W(UCON, 32'h9));
        tbl.push_back(R(UCON, 32'h9));
        tbl.push_back(W(UCON, 32'h0));
        tbl.push_back(R(UCON, 32'h0));
        // byte arriving in the same cycle as the clear
        tbl.push_back(I(0, 0, 1, 8'h01));
        tbl.push_back(I(0, 0, 1, 8'h02));
        tbl.push_back(W(UCON, 32'h0, 0, 0, 1, 8'h03));
        tbl.push_back(R(UCON, 32'h9));
        tbl.push_back(R(RXD0, 32'h01));
        tbl.push_back(R(RXD1, 32'h02));
        tbl.push_back(W(UCON, 32'h0));
        tbl.push_back(R(UCON, 32'h0));
        // transmit handshake
        tbl.push_back(W(TXD, 32'h0000_0106));
        tbl.push_back(R(TXD, 32'h06));
        tbl.push_back(W(UCON, 32'h2));
        tbl.push_back(R(UCON, 32'h0, 0, 1));
        tbl.push_back(I());
        tbl.push_back(W(UCON, 32'h2, 0, 0, 0, 0, 1));
        tbl.push_back(R(UCON, 32'h4, 0, 0, 0, 0, 1));
        tbl.push_back(I());

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset led", {24'd0, led}, 32'h0);
        check("reset digi", {20'd0, digi}, 32'h0);
        check("reset tx_data", {24'd0, tx_data}, 32'h0);
        check("reset irq", {31'd0, irq}, 32'h0);
        check("reset tx_start", {31'd0, tx_start}, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        check("tx_data port", {24'd0, tx_data}, 32'h06);
        check("led port", {24'd0, led}, 32'hA5);
        check("digi port", {20'd0, digi}, 32'hABC);

        // reset in WAIT_B discards the half-received pair
        apply(I(0, 0, 1, 8'h0C), "rst_b0");
        v = I();
        v.rst = 1'b1;
        apply(v, "rst_pulse");
        apply(I(0, 0, 1, 8'h21), "rst_b1");
        check("post-reset led", {24'd0, led}, 32'h0);
        apply(I(0, 0, 1, 8'h33), "rst_b2");
        apply(R(RXD0, 32'h21), "rst_rxd0");
        apply(R(RXD1, 32'h33), "rst_rxd1");
        apply(R(UCON, 32'h1), "rst_ucon");
        apply(R(TL, 32'h0), "rst_tl");

`ifdef PERIPH_SYSTICK_EN
        v = R(SYST, 32'h0);
        v.chk = 1'b0;
        apply(v, "systick_a");
        a = rdata;
        repeat (5) apply(I(), "systick_gap");
        apply(v, "systick_b");
        b = rdata;
        check("systick delta", b - a, 32'd6);
        apply(W(SYST, 32'hDEAD_BEEF), "systick_clr");
        apply(R(SYST, 32'h0), "systick_zero");
        apply(R(SYST, 32'h1), "systick_one");
`else
        a = '0;
        b = '0;
        apply(W(SYST, 32'hDEAD_BEEF), "systick_wr");
        apply(R(SYST, 32'h0), "systick_off");
        check("systick unused", b - a, 32'd0);
`endif

        apply(I(), "tail");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
